// File: rtl/mario_sprite_fetch_if.sv
// Pixel-side bus of the Mario sprite fetcher: scan position, latched sprite state,
// the ROM address/select/data path and the keyed pixel returned to the display mux.
interface mario_sprite_fetch_if;
  // No valid/ready pair: the scan delivers one pixel every cycle and the fetcher always
  // accepts it; outputs describe the pixel sampled three cycles earlier, every cycle.
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        bright;
  logic [9:0]  mario_x;
  logic [9:0]  mario_y;
  logic        moving;
  logic        airborne;
  logic        face_left;
  logic [9:0]  rom_addr;
  logic [2:0]  rom_sel;
  logic [11:0] rom_data;
  logic        sprite_hit;
  logic [11:0] sprite_rgb;

  modport slave (
    input  hCount, vCount, bright, mario_x, mario_y, moving, airborne, face_left, rom_data,
    output rom_addr, rom_sel, sprite_hit, sprite_rgb
  );

  modport master (
    output hCount, vCount, bright, mario_x, mario_y, moving, airborne, face_left, rom_data,
    input  rom_addr, rom_sel, sprite_hit, sprite_rgb
  );
endinterface

// File: rtl/mario_sprite_fetch.sv
// Mario sprite fetcher: per-frame state latch, walk animation, bounding-box test,
// ROM addressing and a three-stage pipeline that keys out transparent pixels.
module mario_sprite_fetch #(
  parameter int          SPRITE_DIM  = 32,
  parameter logic [11:0] TRANSPARENT = 12'h000,
  parameter int          WALK_FRAMES = 8
) (
  input logic            clk,
  input logic            rst_n,
  mario_sprite_fetch_if.slave bus
);

  localparam logic [7:0]  ANIM_LAST = 8'(WALK_FRAMES - 1);
  localparam logic [10:0] DIM       = 11'(SPRITE_DIM);

  logic [9:0]  x_lat;
  logic [9:0]  y_lat;
  logic        frame_valid;
  logic [7:0]  anim_cnt;
  logic        walk_phase;
  logic        in_box_d1;
  logic        in_box_d2;

  logic        frame_latch;
  logic [9:0]  x_eff;
  logic [9:0]  y_eff;
  logic        valid_eff;
  logic [10:0] dx;
  logic [10:0] dy;
  logic        in_box;
  logic        walking;
  logic        opaque;
  logic [2:0]  pose_next;

  // The latch pixel itself must see the freshly captured position, so bypass the shadows.
  always_comb begin
    frame_latch = (bus.hCount == 10'd0) && (bus.vCount == 10'd0);
    x_eff       = frame_latch ? bus.mario_x : x_lat;
    y_eff       = frame_latch ? bus.mario_y : y_lat;
    valid_eff   = frame_latch || frame_valid;
    dx          = {1'b0, bus.hCount} - {1'b0, x_eff};
    dy          = {1'b0, bus.vCount} - {1'b0, y_eff};
    in_box      = !dx[10] && (dx < DIM) && !dy[10] && (dy < DIM) && bus.bright && valid_eff;
    walking     = bus.moving && !bus.airborne;
    opaque      = in_box_d2 && (bus.rom_data != TRANSPARENT);
  end

  // Pose uses the phase as it stood before this latch advances the animation.
  always_comb begin
    pose_next = {2'b00, bus.face_left};
    if (bus.airborne)
      pose_next = {2'b10, bus.face_left};
    else if (bus.moving && walk_phase)
      pose_next = {2'b01, bus.face_left};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_lat          <= '0;
      y_lat          <= '0;
      frame_valid    <= 1'b0;
      anim_cnt       <= '0;
      walk_phase     <= 1'b0;
      in_box_d1      <= 1'b0;
      in_box_d2      <= 1'b0;
      bus.rom_addr   <= '0;
      bus.rom_sel    <= '0;
      bus.sprite_hit <= 1'b0;
      bus.sprite_rgb <= '0;
    end else begin
      if (frame_latch) begin
        x_lat       <= bus.mario_x;
        y_lat       <= bus.mario_y;
        frame_valid <= 1'b1;
        bus.rom_sel <= pose_next;
        if (walking) begin
          if (anim_cnt == ANIM_LAST) begin
            anim_cnt   <= '0;
            walk_phase <= ~walk_phase;
          end else begin
            anim_cnt <= anim_cnt + 8'd1;
          end
        end else begin
          anim_cnt   <= '0;
          walk_phase <= 1'b0;
        end
      end

      if (in_box)
        bus.rom_addr <= {dy[4:0], dx[4:0]};

      in_box_d1      <= in_box;
      in_box_d2      <= in_box_d1;
      bus.sprite_hit <= opaque;
      bus.sprite_rgb <= opaque ? bus.rom_data : 12'h000;
    end
  end

endmodule
